// File: rtl/sap1_pkg.sv
// Shared SAP-1 encodings: opcodes, control-word bit positions, T-state
// one-hot codes and small decode helpers used by the controller blocks.
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Bit positions inside cw = {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
   localparam int CW_CP   = 11;
   localparam int CW_EP   = 10;
   localparam int CW_LM_N = 9;
   localparam int CW_CE_N = 8;
   localparam int CW_LI_N = 7;
   localparam int CW_EI_N = 6;
   localparam int CW_LA_N = 5;
   localparam int CW_EA   = 4;
   localparam int CW_SU   = 3;
   localparam int CW_EU   = 2;
   localparam int CW_LB_N = 1;
   localparam int CW_LO_N = 0;

   localparam logic [11:0] CW_INACTIVE = 12'h3E3;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   typedef enum logic [2:0] {
      I_LDA = 3'd0,
      I_ADD = 3'd1,
      I_SUB = 3'd2,
      I_OUT = 3'd3,
      I_HLT = 3'd4,
      I_NOP = 3'd5
   } instr_e;

   function automatic instr_e decode_op(input logic [3:0] op);
      case (op)
         OP_LDA:  return I_LDA;
         OP_ADD:  return I_ADD;
         OP_SUB:  return I_SUB;
         OP_OUT:  return I_OUT;
         OP_HLT:  return I_HLT;
         default: return I_NOP;
      endcase
   endfunction

   function automatic logic is_one_hot6(input logic [5:0] v);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < 6; i++) begin
         cnt = cnt + {2'b00, v[i]};
      end
      return (cnt == 3'd1);
   endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring with hold; any non-one-hot value
// (upset) falls back to T1 on the next edge.
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic       clk,
   input  logic       clr_n,
   input  logic       hold,
   output logic [5:0] t_state
);

   logic [5:0] ring_r;
   logic [5:0] ring_next_s;

   // Next ring value: recover, hold, or rotate left by one.
   always_comb begin
      ring_next_s = T1;
      if (!is_one_hot6(ring_r)) begin
         ring_next_s = T1;
      end else if (hold) begin
         ring_next_s = ring_r;
      end else begin
         ring_next_s = {ring_r[4:0], ring_r[5]};
      end
   end

   // Ring state register, asynchronously cleared to T1.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ring_r <= T1;
      end else begin
         ring_r <= ring_next_s;
      end
   end

   assign t_state = ring_r;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 instruction sequencer: T-state ring, halt latch and Moore decode
// of {ring, halted, opcode} into the 12-bit control word.
module sap1_controller
   import sap1_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic [3:0]  opcode,
   output logic [11:0] cw,
   output logic [5:0]  t_state,
   output logic        hlt
);

   logic [5:0]  t_state_s;
   logic        hlt_r;
   logic        halt_set_s;
   logic        hold_s;
   logic [11:0] cw_s;
   instr_e      instr_s;

   assign instr_s = decode_op(opcode);

   sap1_ring_counter u_ring (
      .clk     (clk),
      .clr_n   (clr_n),
      .hold    (hold_s),
      .t_state (t_state_s)
   );

   // The halting edge must also freeze the ring, so hold covers it too.
   always_comb begin
      halt_set_s = 1'b0;
      hold_s     = hlt_r;
      if ((t_state_s == T4) && (instr_s == I_HLT) && !hlt_r) begin
         halt_set_s = 1'b1;
         hold_s     = 1'b1;
      end else begin
         halt_set_s = 1'b0;
         hold_s     = hlt_r;
      end
   end

   // Halt latch, cleared only by clr_n.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hlt_r <= 1'b0;
      end else if (halt_set_s) begin
         hlt_r <= 1'b1;
      end else begin
         hlt_r <= hlt_r;
      end
   end

   // Control-word decode; reset and halt force the inactive word.
   always_comb begin
      cw_s = CW_INACTIVE;
      if (!clr_n || hlt_r) begin
         cw_s = CW_INACTIVE;
      end else begin
         case (t_state_s)
            T1: begin
               cw_s[CW_EP]   = 1'b1;
               cw_s[CW_LM_N] = 1'b0;
            end
            T2: begin
               cw_s[CW_CP] = 1'b1;
            end
            T3: begin
               cw_s[CW_CE_N] = 1'b0;
               cw_s[CW_LI_N] = 1'b0;
            end
            T4: begin
               case (instr_s)
                  I_LDA, I_ADD, I_SUB: begin
                     cw_s[CW_LM_N] = 1'b0;
                     cw_s[CW_EI_N] = 1'b0;
                  end
                  I_OUT: begin
                     cw_s[CW_EA]   = 1'b1;
                     cw_s[CW_LO_N] = 1'b0;
                  end
                  default: cw_s = CW_INACTIVE;
               endcase
            end
            T5: begin
               case (instr_s)
                  I_LDA: begin
                     cw_s[CW_CE_N] = 1'b0;
                     cw_s[CW_LA_N] = 1'b0;
                  end
                  I_ADD, I_SUB: begin
                     cw_s[CW_CE_N] = 1'b0;
                     cw_s[CW_LB_N] = 1'b0;
                  end
                  default: cw_s = CW_INACTIVE;
               endcase
            end
            T6: begin
               case (instr_s)
                  I_ADD: begin
                     cw_s[CW_LA_N] = 1'b0;
                     cw_s[CW_EU]   = 1'b1;
                  end
                  I_SUB: begin
                     cw_s[CW_LA_N] = 1'b0;
                     cw_s[CW_EU]   = 1'b1;
                     cw_s[CW_SU]   = 1'b1;
                  end
                  default: cw_s = CW_INACTIVE;
               endcase
            end
            default: cw_s = CW_INACTIVE;
         endcase
      end
   end

   assign cw      = cw_s;
   assign t_state = t_state_s;
   assign hlt     = hlt_r;

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: directed instructions, random
// instruction stream, halt and asynchronous reset, against a step-table model.
module tb_sap1_controller;

   logic        clk;
   logic        clr_n;
   logic [3:0]  opcode;
   logic [11:0] cw;
   logic [5:0]  t_state;
   logic        hlt;

   int checks;
   int errors;

   // Reference model: step 0..5 = T1..T6, plus halted / in-reset flags.
   int m_step;
   bit m_halt;
   bit m_rst;

   sap1_controller dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .opcode  (opcode),
      .cw      (cw),
      .t_state (t_state),
      .hlt     (hlt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] ref_cw(input int step, input logic [3:0] op,
                                          input bit halted, input bit in_rst);
      if (in_rst || halted) return 12'h3E3;
      case (step)
         0: return 12'h5E3;
         1: return 12'hBE3;
         2: return 12'h263;
         3: case (op)
               4'h0, 4'h1, 4'h2: return 12'h1A3;
               4'hE:             return 12'h3F2;
               default:          return 12'h3E3;
            endcase
         4: case (op)
               4'h0:       return 12'h2C3;
               4'h1, 4'h2: return 12'h2E1;
               default:    return 12'h3E3;
            endcase
         5: case (op)
               4'h1:    return 12'h3C7;
               4'h2:    return 12'h3CF;
               default: return 12'h3E3;
            endcase
         default: return 12'h3E3;
      endcase
   endfunction

   task automatic check_all(input string tag);
      logic [11:0] e_cw;
      logic [5:0]  e_t;
      logic        e_h;
      e_cw = ref_cw(m_step, opcode, m_halt, m_rst);
      e_t  = 6'b000001 << m_step;
      e_h  = m_halt;
      checks++;
      assert (cw === e_cw) else begin
         errors++;
         $error("FAIL %s cw observed=%h expected=%h", tag, cw, e_cw);
      end
      checks++;
      assert (t_state === e_t) else begin
         errors++;
         $error("FAIL %s t_state observed=%b expected=%b", tag, t_state, e_t);
      end
      checks++;
      assert (hlt === e_h) else begin
         errors++;
         $error("FAIL %s hlt observed=%b expected=%b", tag, hlt, e_h);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (!m_halt) begin
         if (m_step == 3 && opcode == 4'hF) m_halt = 1'b1;
         else m_step = (m_step + 1) % 6;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   // Starts at a negedge in T1; ends at a negedge back in T1.
   task automatic run_instr(input logic [3:0] op, input string tag);
      opcode = 4'($urandom);
      cycle({tag, "_t2"});
      opcode = 4'($urandom);
      cycle({tag, "_t3"});
      opcode = op;
      cycle({tag, "_t4"});
      cycle({tag, "_t5"});
      cycle({tag, "_t6"});
      cycle({tag, "_t1"});
   endtask

   task automatic do_reset_release();
      @(negedge clk);
      clr_n = 1'b1;
      m_rst = 1'b0;
      #1;
      check_all("release_t1");
   endtask

   initial begin
      logic [3:0] ops [4];
      logic [3:0] op;
      checks = 0;
      errors = 0;
      ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE;

      // Reset held across several edges
      clr_n  = 1'b0;
      opcode = 4'h1;
      m_step = 0; m_halt = 1'b0; m_rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_all("reset");
      do_reset_release();

      run_instr(4'h0, "lda");
      run_instr(4'h1, "add");
      run_instr(4'h2, "sub");
      run_instr(4'hE, "out");
      run_instr(4'h7, "nop7");

      // Random instruction stream (no HLT)
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) op = ops[$urandom_range(0, 3)];
         else op = 4'($urandom_range(0, 14));
         run_instr(op, "rand");
      end

      // HLT: freeze at T4, opcode ignored while halted
      opcode = 4'($urandom);
      cycle("hlt_t2");
      cycle("hlt_t3");
      opcode = 4'hF;
      cycle("hlt_t4");
      cycle("hlt_set");
      for (int i = 0; i < 20; i++) begin
         opcode = 4'($urandom);
         cycle("halted");
      end
      #2;
      clr_n = 1'b0;
      m_step = 0; m_halt = 1'b0; m_rst = 1'b1;
      #1;
      check_all("hlt_clear");
      do_reset_release();

      // Asynchronous reset between edges in T5 of ADD
      opcode = 4'h3;
      cycle("arst_t2");
      cycle("arst_t3");
      opcode = 4'h1;
      cycle("arst_t4");
      cycle("arst_t5");
      #2;
      clr_n = 1'b0;
      m_step = 0; m_halt = 1'b0; m_rst = 1'b1;
      #1;
      check_all("arst_mid_t5");
      do_reset_release();
      run_instr(4'h2, "post_arst_sub");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
